// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two byte requesters, the arbiter and a uart_tx core.
// The slave modport is the arbiter's view; the master modport is everything around it.
interface uart_tx_arbiter_if;
  logic       req0;
  logic       req1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       ack0;
  logic       ack1;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  modport slave (
    input  req0, req1, data0, data1, tx_done,
    output ack0, ack1, tx_start, tx_data
  );

  modport master (
    output req0, req1, data0, data1, tx_done,
    input  ack0, ack1, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one uart_tx from two byte requesters.
// Every frame goes START -> WAIT (tx_done or timeout) -> GAP before the next grant.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES     = 14,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                 clk_3125,
  input  logic                 rst_n,
  uart_tx_arbiter_if.slave     bus,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 grant_id,
  output logic                 timeout_err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic          last_grant, last_grant_nxt;
  logic          grant_id_nxt;
  logic          tx_start_q, tx_start_nxt;
  logic [7:0]    tx_data_q, tx_data_nxt;
  logic          ack0_q, ack0_nxt;
  logic          ack1_q, ack1_nxt;
  logic          busy_nxt;
  logic          timeout_err_nxt;
  logic          timeout_hit;
  logic          pick;

  // All outputs are registers so the grant pulse lands on the sampling edge itself.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      last_grant  <= last_grant_nxt;
      grant_id    <= grant_id_nxt;
      tx_start_q  <= tx_start_nxt;
      tx_data_q   <= tx_data_nxt;
      ack0_q      <= ack0_nxt;
      ack1_q      <= ack1_nxt;
      busy        <= busy_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  // On a tie the requester that did not own the previous frame wins.
  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) begin
      pick = ~last_grant;
    end else if (bus.req1) begin
      pick = 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    gap_cnt_nxt    = gap_cnt;
    last_grant_nxt = last_grant;
    grant_id_nxt   = grant_id;
    tx_start_nxt   = 1'b0;
    tx_data_nxt    = tx_data_q;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    timeout_hit    = 1'b0;

    case (state)
      IDLE: begin
        wait_cnt_nxt = '0;
        gap_cnt_nxt  = '0;
        if (bus.req0 || bus.req1) begin
          state_nxt      = START;
          tx_start_nxt   = 1'b1;
          last_grant_nxt = pick;
          grant_id_nxt   = pick;
          if (pick) begin
            ack1_nxt    = 1'b1;
            tx_data_nxt = bus.data1;
          end else begin
            ack0_nxt    = 1'b1;
            tx_data_nxt = bus.data0;
          end
        end
      end

      START: begin
        state_nxt    = WAIT;
        wait_cnt_nxt = '0;
      end

      // tx_done takes priority over a timeout landing on the same edge.
      WAIT: begin
        if (bus.tx_done) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit  = 1'b1;
          state_nxt    = GAP;
          gap_cnt_nxt  = '0;
          wait_cnt_nxt = WAIT_MAX;
        end else if (wait_cnt != WAIT_MAX) begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      GAP: begin
        wait_cnt_nxt = '0;
        if (gap_cnt == GAP_LAST) begin
          state_nxt   = IDLE;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A fresh timeout beats a simultaneous clear request.
  always_comb begin
    timeout_err_nxt = timeout_err;
    if (timeout_hit) begin
      timeout_err_nxt = 1'b1;
    end else if (err_clr) begin
      timeout_err_nxt = 1'b0;
    end
    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grants, round-robin spacing, timeout, reset abort
// and withdrawn requests, with a tx_done responder standing in for uart_tx.
module tb_uart_tx_arbiter;

  logic clk_3125;
  logic rst_n;
  logic err_clr;
  logic busy;
  logic grant_id;
  logic timeout_err;

  logic auto_en;
  logic auto_tx_done;
  logic man_tx_done;
  int   done_cd;

  int cyc;
  int total;
  int bad;
  int start_count;
  int ack1_count;
  int both_ack;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .GAP_CYCLES     (14),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk_3125    (clk_3125),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .err_clr     (err_clr),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  assign bus.tx_done = auto_tx_done | man_tx_done;

  initial begin
    clk_3125 = 1'b0;
    forever #160 clk_3125 = ~clk_3125;
  end

  always @(posedge clk_3125) cyc <= cyc + 1;

  // Answers each tx_start with a tx_done sampled exactly 154 edges later.
  always @(negedge clk_3125) begin
    auto_tx_done <= 1'b0;
    if (auto_en && bus.tx_start) begin
      done_cd <= 153;
    end else if (done_cd > 0) begin
      done_cd <= done_cd - 1;
      if (done_cd == 1) auto_tx_done <= 1'b1;
    end
  end

  always @(negedge clk_3125) begin
    if (bus.tx_start) start_count <= start_count + 1;
    if (bus.ack1) ack1_count <= ack1_count + 1;
    if (bus.ack0 && bus.ack1) both_ack <= both_ack + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [7:0] d0,
                               input logic r1, input logic [7:0] d1);
    @(negedge clk_3125);
    bus.req0  = r0;
    bus.data0 = d0;
    bus.req1  = r1;
    bus.data1 = d1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_3125);
  endtask

  task automatic waitStart(output int at, input int limit);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_3125);
      if (bus.tx_start) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic waitBusyLow(output int at, input int limit);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_3125);
      if (!busy) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic waitTimeout(output int at, input int limit);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_3125);
      if (timeout_err) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic pulseReset();
    @(negedge clk_3125);
    rst_n = 1'b0;
    @(negedge clk_3125);
    rst_n = 1'b1;
  endtask

  initial begin
    int s;
    int t;
    int n0;
    int ts[3];
    logic [7:0] td[3];
    logic       ta0[3];

    cyc          = 0;
    total        = 0;
    bad          = 0;
    start_count  = 0;
    ack1_count   = 0;
    both_ack     = 0;
    done_cd      = 0;
    auto_en      = 1'b0;
    auto_tx_done = 1'b0;
    man_tx_done  = 1'b0;
    err_clr      = 1'b0;
    bus.req0     = 1'b0;
    bus.req1     = 1'b0;
    bus.data0    = 8'h00;
    bus.data1    = 8'h00;
    rst_n        = 1'b0;

    waitCycles(3);
    checkOutput("rst_tx_start", bus.tx_start, 0);
    checkOutput("rst_tx_data", bus.tx_data, 8'h00);
    checkOutput("rst_ack0", bus.ack0, 0);
    checkOutput("rst_ack1", bus.ack1, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    waitCycles(2);

    // Single request from requester 0.
    auto_en = 1'b1;
    applyStimulus(1, 8'h52, 0, 8'h00);
    waitStart(s, 10);
    checkOutput("t1_start_seen", (s >= 0), 1);
    checkOutput("t1_ack0", bus.ack0, 1);
    checkOutput("t1_ack1", bus.ack1, 0);
    checkOutput("t1_tx_data", bus.tx_data, 8'h52);
    checkOutput("t1_grant_id", grant_id, 0);
    checkOutput("t1_busy", busy, 1);
    bus.req0 = 1'b0;
    waitCycles(1);
    checkOutput("t1_start_drop", bus.tx_start, 0);
    checkOutput("t1_ack0_drop", bus.ack0, 0);
    checkOutput("t1_data_hold", bus.tx_data, 8'h52);
    waitBusyLow(t, 400);
    checkOutput("t1_busy_low_at", t - s, 154 + 14);

    // Both requesters held; a fresh reset makes the first tie go to requester 0.
    pulseReset();
    applyStimulus(1, 8'h47, 1, 8'h42);
    for (int k = 0; k < 3; k++) begin
      waitStart(ts[k], 400);
      td[k]  = bus.tx_data;
      ta0[k] = bus.ack0;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    checkOutput("t2_data0", td[0], 8'h47);
    checkOutput("t2_data1", td[1], 8'h42);
    checkOutput("t2_data2", td[2], 8'h47);
    checkOutput("t2_ack0_first", ta0[0], 1);
    checkOutput("t2_ack0_second", ta0[1], 0);
    checkOutput("t2_gap01", ts[1] - ts[0], 169);
    checkOutput("t2_gap12", ts[2] - ts[1], 169);
    waitBusyLow(t, 400);
    checkOutput("t2_idle", (t >= 0), 1);

    // tx_done never arrives.
    auto_en = 1'b0;
    applyStimulus(1, 8'h11, 0, 8'h00);
    waitStart(s, 10);
    bus.req0 = 1'b0;
    waitTimeout(t, 400);
    checkOutput("t3_timeout_at", t - s, 1 + 200);
    waitBusyLow(t, 100);
    checkOutput("t3_idle_at", t - s, 1 + 200 + 14);
    checkOutput("t3_err_sticky", timeout_err, 1);
    @(negedge clk_3125);
    err_clr = 1'b1;
    @(negedge clk_3125);
    err_clr = 1'b0;
    checkOutput("t3_err_cleared", timeout_err, 0);

    // tx_done while IDLE and while in GAP is ignored.
    @(negedge clk_3125);
    man_tx_done = 1'b1;
    @(negedge clk_3125);
    man_tx_done = 1'b0;
    waitCycles(2);
    checkOutput("t4_idle_busy", busy, 0);
    checkOutput("t4_idle_start", bus.tx_start, 0);
    auto_en = 1'b1;
    n0 = start_count;
    applyStimulus(0, 8'h00, 1, 8'h5A);
    waitStart(s, 10);
    bus.req1 = 1'b0;
    waitCycles(160);
    man_tx_done = 1'b1;
    @(negedge clk_3125);
    man_tx_done = 1'b0;
    waitBusyLow(t, 100);
    checkOutput("t4_gap_idle_at", t - s, 154 + 14);
    waitCycles(3);
    checkOutput("t4_one_start", start_count - n0, 1);

    // Reset 50 clocks into WAIT, then a normal grant to requester 1.
    auto_en = 1'b0;
    applyStimulus(1, 8'h33, 0, 8'h00);
    waitStart(s, 10);
    bus.req0 = 1'b0;
    waitCycles(50);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_tx_data", bus.tx_data, 8'h00);
    checkOutput("t5_grant_id", grant_id, 0);
    checkOutput("t5_ack0", bus.ack0, 0);
    checkOutput("t5_tx_start", bus.tx_start, 0);
    n0 = start_count;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(2);
    checkOutput("t5_no_start", start_count - n0, 0);
    auto_en = 1'b1;
    applyStimulus(0, 8'h00, 1, 8'h3F);
    waitStart(s, 10);
    checkOutput("t5_ack1", bus.ack1, 1);
    checkOutput("t5_ack0_off", bus.ack0, 0);
    checkOutput("t5_data", bus.tx_data, 8'h3F);
    checkOutput("t5_grant1", grant_id, 1);
    bus.req1 = 1'b0;
    waitBusyLow(t, 400);

    // Requester 1 raises and withdraws its request during WAIT.
    n0 = ack1_count;
    applyStimulus(1, 8'h52, 0, 8'h00);
    waitStart(s, 10);
    bus.req0 = 1'b0;
    waitCycles(20);
    bus.req1  = 1'b1;
    bus.data1 = 8'hEE;
    waitCycles(10);
    bus.req1 = 1'b0;
    waitBusyLow(t, 400);
    waitCycles(5);
    checkOutput("t6_no_ack1", ack1_count - n0, 0);
    checkOutput("t6_idle", busy, 0);
    checkOutput("t6_grant_id", grant_id, 0);

    checkOutput("ack_exclusive", both_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
